// File: rtl/pult_io_core.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : pult_io_core                                                   |
// | Purpose  : Half-duplex RS-485 panel (pult) link engine. Host words are    |
// |            queued in a TX FIFO and sent as UART frames (LSB first,        |
// |            byte 0 first). Received frames are packed back into host words |
// |            and queued in an RX FIFO with first-word-fall-through output.  |
// | Option   : define PULT_IO_PARITY_EN for 8E1 frames (default build: 8N1).  |
// | Ports    : clk_io, rst            - clock, async active-high reset        |
// |            data_i, data_o         - serial line in / out                  |
// |            dir_485                - transceiver direction (1 = drive)     |
// |            wr_en, data_from_host  - host push into TX FIFO                |
// |            tx_full, busy          - TX FIFO full / transmitter active     |
// |            rd_en, data_to_host    - host pop / RX FIFO head word          |
// |            ready, rx_err          - RX word available / sticky RX error   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module pult_io_core #(
  parameter int G_HOST_DWIDTH = 32,
  parameter int G_FIFO_DEPTH  = 16,
  parameter int G_BAUD_DIV    = 64
) (
  input  logic                     clk_io,
  input  logic                     rst,
  input  logic                     data_i,
  output logic                     data_o,
  output logic                     dir_485,
  input  logic                     wr_en,
  input  logic [G_HOST_DWIDTH-1:0] data_from_host,
  input  logic                     rd_en,
  output logic [G_HOST_DWIDTH-1:0] data_to_host,
  output logic                     busy,
  output logic                     ready,
  output logic                     tx_full,
  output logic                     rx_err
);

  localparam int C_NB  = G_HOST_DWIDTH / 8;
  localparam int C_AW  = $clog2(G_FIFO_DEPTH);
  localparam int C_BW  = $clog2(G_BAUD_DIV);
  localparam int C_NBW = (C_NB > 1) ? $clog2(C_NB) : 1;

  localparam logic [C_BW-1:0]  C_BIT_LAST  = C_BW'(G_BAUD_DIV - 1);
  localparam logic [C_BW-1:0]  C_HALF_LAST = C_BW'(G_BAUD_DIV / 2 - 1);
  localparam logic [C_NBW-1:0] C_BYTE_LAST = C_NBW'(C_NB - 1);
  localparam logic [C_AW:0]    C_DEPTH     = (C_AW + 1)'(G_FIFO_DEPTH);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_LEAD  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_DATA  = 3'd3;
  localparam logic [2:0] TX_STOP  = 3'd5;
  localparam logic [2:0] TX_TRAIL = 3'd6;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd4;
  localparam logic [2:0] RX_WAIT  = 3'd5;
`ifdef PULT_IO_PARITY_EN
  localparam logic [2:0] TX_PAR   = 3'd4;
  localparam logic [2:0] RX_PAR   = 3'd3;
`endif

  // ------------------------------------------------------------------ TX FIFO
  logic [G_HOST_DWIDTH-1:0] r_tx_mem [G_FIFO_DEPTH];
  logic [C_AW-1:0]          r_tx_wptr, r_tx_rptr;
  logic [C_AW:0]            r_tx_cnt;
  logic                     w_tx_push, w_tx_pop, w_tx_empty;

  assign tx_full    = (r_tx_cnt == C_DEPTH);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = wr_en && !tx_full;

  always_ff @(posedge clk_io) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= data_from_host;
  end

  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // ------------------------------------------------------------------ TX FSM
  logic [2:0]               r_tx_state, w_tx_state_nxt;
  logic [C_BW-1:0]          r_tx_baud;
  logic [2:0]               r_tx_bit_cnt;
  logic [C_NBW-1:0]         r_tx_byte_cnt;
  logic [G_HOST_DWIDTH-1:0] r_tx_shreg;
  logic                     w_tx_bit_end, w_tx_byte_last;

  assign w_tx_bit_end   = (r_tx_baud == C_BIT_LAST);
  assign w_tx_byte_last = (r_tx_byte_cnt == C_BYTE_LAST);
  // Word loads happen either from IDLE or back-to-back at the end of the
  // last stop bit of the previous word (no LEAD/TRAIL between words).
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == TX_IDLE) ||
                     (r_tx_state == TX_STOP && w_tx_bit_end && w_tx_byte_last));
  assign busy     = !w_tx_empty || (r_tx_state != TX_IDLE);

  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (!w_tx_empty)  w_tx_state_nxt = TX_LEAD;
      TX_LEAD:  if (w_tx_bit_end) w_tx_state_nxt = TX_START;
      TX_START: if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
      TX_DATA:
        if (w_tx_bit_end && r_tx_bit_cnt == 3'd7) begin
`ifdef PULT_IO_PARITY_EN
          w_tx_state_nxt = TX_PAR;
`else
          w_tx_state_nxt = TX_STOP;
`endif
        end
`ifdef PULT_IO_PARITY_EN
      TX_PAR:   if (w_tx_bit_end) w_tx_state_nxt = TX_STOP;
`endif
      TX_STOP:
        if (w_tx_bit_end) begin
          if (!w_tx_byte_last || !w_tx_empty) w_tx_state_nxt = TX_START;
          else                                w_tx_state_nxt = TX_TRAIL;
        end
      TX_TRAIL: if (w_tx_bit_end) w_tx_state_nxt = TX_IDLE;
      default:  w_tx_state_nxt = TX_IDLE;
    endcase
  end

`ifdef PULT_IO_PARITY_EN
  logic r_tx_par;
`endif

  always_comb begin
    dir_485 = (r_tx_state != TX_IDLE);
    case (r_tx_state)
      TX_START: data_o = 1'b0;
      TX_DATA:  data_o = r_tx_shreg[0];
`ifdef PULT_IO_PARITY_EN
      TX_PAR:   data_o = r_tx_par;
`endif
      default:  data_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) begin
      r_tx_baud     <= '0;
      r_tx_bit_cnt  <= '0;
      r_tx_byte_cnt <= '0;
      r_tx_shreg    <= '0;
    end else begin
      if (r_tx_state == TX_IDLE || w_tx_bit_end) r_tx_baud <= '0;
      else                                        r_tx_baud <= r_tx_baud + 1'b1;

      if (w_tx_pop) begin
        r_tx_shreg    <= r_tx_mem[r_tx_rptr];
        r_tx_byte_cnt <= '0;
      end else if (r_tx_state == TX_STOP && w_tx_bit_end && !w_tx_byte_last) begin
        r_tx_byte_cnt <= r_tx_byte_cnt + 1'b1;
      end

      if (r_tx_state == TX_START && w_tx_bit_end) r_tx_bit_cnt <= '0;
      // Shifting right after each data bit leaves the next byte in [7:0].
      if (r_tx_state == TX_DATA && w_tx_bit_end) begin
        r_tx_shreg   <= r_tx_shreg >> 1;
        r_tx_bit_cnt <= r_tx_bit_cnt + 1'b1;
      end
    end
  end

`ifdef PULT_IO_PARITY_EN
  // Even parity: running XOR of the data bits as they leave the shifter.
  always_ff @(posedge clk_io or posedge rst) begin
    if (rst)                                           r_tx_par <= 1'b0;
    else if (r_tx_state == TX_START && w_tx_bit_end)   r_tx_par <= 1'b0;
    else if (r_tx_state == TX_DATA && w_tx_bit_end)    r_tx_par <= r_tx_par ^ r_tx_shreg[0];
  end
`endif

  // ------------------------------------------------------------------ RX line
  logic r_rx_meta, r_rx_sync, r_rx_prev;

  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= data_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // ------------------------------------------------------------------ RX FSM
  logic [2:0]               r_rx_state, w_rx_state_nxt;
  logic [C_BW-1:0]          r_rx_baud;
  logic [2:0]               r_rx_bit_cnt;
  logic [C_NBW-1:0]         r_rx_byte_cnt;
  logic [7:0]               r_rx_shreg;
  logic [G_HOST_DWIDTH-1:0] r_rx_word, w_rx_word;
  logic                     w_rx_sample, w_rx_start_ok, w_rx_accept, w_rx_frame_err;
  logic                     w_rx_par_ok, w_rx_word_done, w_rx_hold;

  // Sampling points: half a bit after the start edge, then every full bit.
  // The receiver is frozen while we drive the line so our own echo is ignored.
  assign w_rx_sample = !dir_485 &&
                       (((r_rx_state == RX_START) && (r_rx_baud == C_HALF_LAST)) ||
                        ((r_rx_state == RX_DATA || r_rx_state == RX_STOP
`ifdef PULT_IO_PARITY_EN
                          || r_rx_state == RX_PAR
`endif
                         ) && (r_rx_baud == C_BIT_LAST)));
  assign w_rx_hold      = dir_485 || w_rx_sample ||
                          (r_rx_state == RX_IDLE) || (r_rx_state == RX_WAIT);
  assign w_rx_start_ok  = (r_rx_state == RX_START) && w_rx_sample && !r_rx_sync;
  assign w_rx_accept    = (r_rx_state == RX_STOP) && w_rx_sample && r_rx_sync && w_rx_par_ok;
  assign w_rx_frame_err = (r_rx_state == RX_STOP) && w_rx_sample && !(r_rx_sync && w_rx_par_ok);
  assign w_rx_word_done = w_rx_accept && (r_rx_byte_cnt == C_BYTE_LAST);

  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_state_nxt;
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    if (dir_485) begin
      w_rx_state_nxt = RX_IDLE;
    end else begin
      case (r_rx_state)
        RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = RX_START;
        RX_START: if (w_rx_sample) w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        RX_DATA:
          if (w_rx_sample && r_rx_bit_cnt == 3'd7) begin
`ifdef PULT_IO_PARITY_EN
            w_rx_state_nxt = RX_PAR;
`else
            w_rx_state_nxt = RX_STOP;
`endif
          end
`ifdef PULT_IO_PARITY_EN
        RX_PAR:   if (w_rx_sample) w_rx_state_nxt = RX_STOP;
`endif
        RX_STOP:  if (w_rx_sample) w_rx_state_nxt = w_rx_accept ? RX_IDLE : RX_WAIT;
        RX_WAIT:  if (r_rx_sync) w_rx_state_nxt = RX_IDLE;
        default:  w_rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) begin
      r_rx_baud     <= '0;
      r_rx_bit_cnt  <= '0;
      r_rx_byte_cnt <= '0;
      r_rx_shreg    <= '0;
      r_rx_word     <= '0;
    end else begin
      if (w_rx_hold) r_rx_baud <= '0;
      else           r_rx_baud <= r_rx_baud + 1'b1;

      if (w_rx_start_ok) r_rx_bit_cnt <= '0;
      if (w_rx_sample && r_rx_state == RX_DATA) begin
        r_rx_shreg   <= {r_rx_sync, r_rx_shreg[7:1]};
        r_rx_bit_cnt <= r_rx_bit_cnt + 1'b1;
      end

      if (w_rx_accept) begin
        r_rx_word[8*int'(r_rx_byte_cnt) +: 8] <= r_rx_shreg;
        r_rx_byte_cnt <= w_rx_word_done ? '0 : r_rx_byte_cnt + 1'b1;
      end else if (w_rx_frame_err) begin
        r_rx_byte_cnt <= '0;
      end
    end
  end

`ifdef PULT_IO_PARITY_EN
  logic r_rx_par_acc, r_rx_par_err;
  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) begin
      r_rx_par_acc <= 1'b0;
      r_rx_par_err <= 1'b0;
    end else if (w_rx_start_ok) begin
      r_rx_par_acc <= 1'b0;
      r_rx_par_err <= 1'b0;
    end else if (w_rx_sample && r_rx_state == RX_DATA) begin
      r_rx_par_acc <= r_rx_par_acc ^ r_rx_sync;
    end else if (w_rx_sample && r_rx_state == RX_PAR) begin
      r_rx_par_err <= r_rx_par_acc ^ r_rx_sync;
    end
  end
  assign w_rx_par_ok = !r_rx_par_err;
`else
  assign w_rx_par_ok = 1'b1;
`endif

  // Completed word = earlier bytes already stored plus the byte just framed.
  always_comb begin
    w_rx_word = r_rx_word;
    w_rx_word[8*(C_NB-1) +: 8] = r_rx_shreg;
  end

  // ------------------------------------------------------------------ RX FIFO
  logic [G_HOST_DWIDTH-1:0] r_rx_mem [G_FIFO_DEPTH];
  logic [C_AW-1:0]          r_rx_wptr, r_rx_rptr;
  logic [C_AW:0]            r_rx_cnt;
  logic                     w_rx_full, w_rx_push, w_rx_pop, w_rx_ovf;

  assign w_rx_full    = (r_rx_cnt == C_DEPTH);
  assign ready        = (r_rx_cnt != '0);
  assign w_rx_pop     = rd_en && ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_rx_push    = w_rx_word_done && (!w_rx_full || w_rx_pop);
  assign w_rx_ovf     = w_rx_word_done && w_rx_full && !w_rx_pop;
  assign data_to_host = ready ? r_rx_mem[r_rx_rptr] : '0;

  always_ff @(posedge clk_io) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_rx_word;
  end

  always_ff @(posedge clk_io or posedge rst) begin
    if (rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
      rx_err    <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      // Set has priority over the clear from rd_en.
      if (w_rx_frame_err || w_rx_ovf) rx_err <= 1'b1;
      else if (rd_en)                 rx_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pult_io_core.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_pult_io_core                                                |
// | Purpose  : Self-checking bench for pult_io_core (32-bit words, depth 4,   |
// |            4 clocks per bit). Directed scenarios followed by a random     |
// |            mix of RX words, host pops and TX bursts, checked against a    |
// |            frame-level reference model (word queues and bit lists).       |
// | Option   : PULT_IO_PARITY_EN selects 8E1 expectations and parity tests.   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_pult_io_core;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int NB    = DW / 8;
`ifdef PULT_IO_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic          clk_io = 1'b0;
  logic          rst    = 1'b1;
  logic          data_i = 1'b1;
  logic          wr_en  = 1'b0;
  logic          rd_en  = 1'b0;
  logic [DW-1:0] data_from_host = '0;
  logic [DW-1:0] data_to_host;
  logic          data_o, dir_485, busy, ready, tx_full, rx_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_io = ~clk_io;

  pult_io_core #(
    .G_HOST_DWIDTH (DW),
    .G_FIFO_DEPTH  (DEPTH),
    .G_BAUD_DIV    (DIV)
  ) dut (
    .clk_io         (clk_io),
    .rst            (rst),
    .data_i         (data_i),
    .data_o         (data_o),
    .dir_485        (dir_485),
    .wr_en          (wr_en),
    .data_from_host (data_from_host),
    .rd_en          (rd_en),
    .data_to_host   (data_to_host),
    .busy           (busy),
    .ready          (ready),
    .tx_full        (tx_full),
    .rx_err         (rx_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: RX FIFO contents as a queue, sticky error flag.
  logic [31:0] mq[$];
  bit          merr = 1'b0;
  logic [31:0] tx_words[$];
`ifdef PULT_IO_PARITY_EN
  bit          corrupt_par = 1'b0;
`endif

  // All input-driving tasks start and end just after a rising edge.
  task automatic drive_bit(input logic v);
    data_i = v;
    repeat (DIV) @(posedge clk_io);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PULT_IO_PARITY_EN
    drive_bit((^b) ^ corrupt_par);
`endif
    drive_bit(!bad_stop);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  // bad_idx in 0..NB-1 corrupts that byte's stop bit and abandons the word.
  task automatic send_word(input logic [31:0] w, input int bad_idx);
    for (int j = 0; j < NB; j++) begin
      send_byte(w[8*j +: 8], j == bad_idx);
      if (j == bad_idx) break;
    end
    if (bad_idx >= 0 && bad_idx < NB) merr = 1'b1;
    else if (mq.size() < DEPTH)       mq.push_back(w);
    else                              merr = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] head;
    head = (mq.size() > 0) ? mq[0] : 32'h0;
    check_val({tag, "_ready"}, {31'b0, ready}, {31'b0, mq.size() > 0});
    check_val({tag, "_data"},  data_to_host, head);
    check_val({tag, "_err"},   {31'b0, rx_err}, {31'b0, merr});
  endtask

  task automatic host_pop();
    logic [31:0] dummy;
    rd_en = 1'b1;
    @(posedge clk_io);
    #1;
    rd_en = 1'b0;
    if (mq.size() > 0) dummy = mq.pop_front();
    merr = 1'b0;
  endtask

  // Writes tx_words[0..n-1] on consecutive cycles, records the line until
  // the direction pin drops, then compares against the frame-level expectation.
  task automatic tx_burst(input int n, input string tag);
    bit rec_do[$], rec_dir[$], rec_busy[$], rec_full[$];
    bit eb[$];
    bit seen = 1'b0, done = 1'b0;
    int cyc = 0, f = -1, l = -1, nacc, idx;
    logic [7:0] b;
    while (!done && cyc < 6000) begin
      if (cyc < n) begin
        wr_en = 1'b1;
        data_from_host = tx_words[cyc];
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk_io);
      rec_do.push_back(data_o);
      rec_dir.push_back(dir_485);
      rec_busy.push_back(busy);
      rec_full.push_back(tx_full);
      if (dir_485) seen = 1'b1;
      else if (seen) done = 1'b1;
      @(posedge clk_io);
      #1;
      cyc++;
    end
    wr_en = 1'b0;
    if (!done) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < rec_dir.size(); i++) begin
      if (rec_dir[i]) begin
        if (f < 0) f = i;
        l = i;
      end
    end
    // An idle transmitter takes the first word immediately, so one word sits
    // in the shifter and DEPTH more fit in the FIFO; later writes are dropped.
    nacc = (n < DEPTH + 1) ? n : DEPTH + 1;
    check_val({tag, "_dir_rise"}, f, 2);
    check_val({tag, "_busy_first"}, {31'b0, rec_busy[1]}, 32'd1);
    check_val({tag, "_dir_len"}, l - f + 1, DIV * (2 + nacc * NB * FRAME));
    check_val({tag, "_busy_fall"}, {31'b0, rec_busy[l+1]}, 32'd0);
    check_val({tag, "_idle_mark"}, {31'b0, rec_do[l+1]}, 32'd1);
    if (n >= DEPTH + 1) begin
      check_val({tag, "_full_before"}, {31'b0, rec_full[DEPTH]}, 32'd0);
      check_val({tag, "_full_after"},  {31'b0, rec_full[DEPTH+1]}, 32'd1);
    end
    eb.push_back(1'b1);
    for (int w = 0; w < nacc; w++) begin
      for (int j = 0; j < NB; j++) begin
        b = tx_words[w][8*j +: 8];
        eb.push_back(1'b0);
        for (int k = 0; k < 8; k++) eb.push_back(b[k]);
`ifdef PULT_IO_PARITY_EN
        eb.push_back(^b);
`endif
        eb.push_back(1'b1);
      end
    end
    eb.push_back(1'b1);
    for (int k = 0; k < eb.size(); k++) begin
      idx = f + k * DIV + DIV / 2;
      if (idx < rec_do.size())
        check_val($sformatf("%s_bit%0d", tag, k), {31'b0, rec_do[idx]}, {31'b0, eb[k]});
      else
        check_val($sformatf("%s_bit%0d_missing", tag, k), 32'd0, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] w;
    int op, nb;
    // Reset state
    repeat (3) @(posedge clk_io);
    #1;
    check_val("rst_data_o",  {31'b0, data_o},  32'd1);
    check_val("rst_dir",     {31'b0, dir_485}, 32'd0);
    check_val("rst_busy",    {31'b0, busy},    32'd0);
    check_val("rst_ready",   {31'b0, ready},   32'd0);
    check_val("rst_tx_full", {31'b0, tx_full}, 32'd0);
    check_val("rst_rx_err",  {31'b0, rx_err},  32'd0);
    check_val("rst_rx_data", data_to_host,     32'd0);
    @(negedge clk_io);
    rst = 1'b0;
    @(posedge clk_io);
    #1;

    // Single word transmit
    tx_words = '{32'h12345678};
    tx_burst(1, "tx_single");

    // Receive one word, then pop it
    send_word(32'hDEADBEEF, -1);
    check_rx("rx_word");
    host_pop();
    check_rx("rx_pop");

    // Six back-to-back writes: five accepted, no LEAD/TRAIL between words
    tx_words = '{32'h01020304, 32'hA1B2C3D4, 32'hFFFF0000, 32'h80000001, 32'h5A5A5A5A, 32'h77777777};
    tx_burst(6, "tx_burst");

    // Framing error on first byte, then clear with rd_en on empty FIFO
    send_word(32'h11223344, 0);
    check_rx("rx_frame_err");
    host_pop();
    check_rx("rx_err_clear");

    // Overflow: five words without reading
    for (int i = 0; i < 5; i++) send_word(32'hC0DE0000 + i, -1);
    check_rx("rx_overflow");
    for (int i = 0; i < DEPTH; i++) begin
      host_pop();
      check_rx($sformatf("rx_drain%0d", i));
    end

    // Asynchronous reset in the middle of a byte of zeros
    data_from_host = 32'h0;
    wr_en = 1'b1;
    @(posedge clk_io);
    #1;
    wr_en = 1'b0;
    repeat (20) @(posedge clk_io);
    #1;
    check_val("pre_rst_dir",  {31'b0, dir_485}, 32'd1);
    check_val("pre_rst_data", {31'b0, data_o},  32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_data", {31'b0, data_o},  32'd1);
    check_val("async_rst_dir",  {31'b0, dir_485}, 32'd0);
    check_val("async_rst_busy", {31'b0, busy},    32'd0);
    @(negedge clk_io);
    rst = 1'b0;
    mq.delete();
    merr = 1'b0;
    @(posedge clk_io);
    #1;
    tx_words = '{32'h0BADF00D};
    tx_burst(1, "tx_after_rst");

`ifdef PULT_IO_PARITY_EN
    tx_words = '{32'h00000001};
    tx_burst(1, "tx_parity");
    corrupt_par = 1'b1;
    send_byte(8'hA5, 1'b0);
    corrupt_par = 1'b0;
    merr = 1'b1;
    check_rx("rx_parity_err");
    host_pop();
    check_rx("rx_parity_clear");
`endif

    // Random mix
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        w = $urandom;
        send_word(w, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NB - 1)) : -1);
        check_rx($sformatf("rnd%0d_rx", it));
      end else if (op <= 6) begin
        host_pop();
        check_rx($sformatf("rnd%0d_pop", it));
      end else begin
        nb = $urandom_range(1, 2);
        tx_words.delete();
        for (int i = 0; i < nb; i++) tx_words.push_back($urandom);
        tx_burst(nb, $sformatf("rnd%0d_tx", it));
        check_rx($sformatf("rnd%0d_rx_quiet", it));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
